// File: rtl/muldiv_sched_if.sv
// muldiv_sched_if: EX-stage handshake and result bus for the multiply/divide scheduler
interface muldiv_sched_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        int_flush;
    logic        exe_stall;
    logic [63:0] hilo_out;
    logic        hilo_valid;
    logic        busy;
    modport master (
        output start, op, src_a, src_b, int_flush,
        input  exe_stall, hilo_out, hilo_valid, busy
    );
    modport slave (
        input  start, op, src_a, src_b, int_flush,
        output exe_stall, hilo_out, hilo_valid, busy
    );
endinterface

// File: rtl/muldiv_sched.sv
// muldiv_sched: multi-cycle MULT/MULTU/DIV/DIVU unit with pipeline stall and flush control
module muldiv_sched (
    input logic           clk,
    input logic           reset,
    muldiv_sched_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3;
    logic [1:0]  state_q, state_d;
    logic        mul_cnt_q, mul_cnt_d;
    logic [4:0]  div_cnt_q, div_cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic        neg_q, neg_d, rneg_q, rneg_d;
    logic [63:0] prod_q, prod_d, res_q, res_d, hilo_q, hilo_d;
    logic        sgn, ge;
    logic [31:0] abs_a, abs_b, q_nx, r_nx;
    logic [32:0] sh, sub;
    logic [47:0] mpart;
    logic [63:0] full;
    // Datapath: operand magnitudes, one restoring-divide step, one 32x16 partial product
    always_comb begin
        sgn   = ~bus.op[0];
        abs_a = (sgn && bus.src_a[31]) ? -bus.src_a : bus.src_a;
        abs_b = (sgn && bus.src_b[31]) ? -bus.src_b : bus.src_b;
        sh    = {r_q, a_q[31]};
        sub   = sh - {1'b0, b_q};
        ge    = ~sub[32];
        q_nx  = {a_q[30:0], ge};
        r_nx  = ge ? sub[31:0] : sh[31:0];
        mpart = {16'b0, a_q} * {32'b0, mul_cnt_q ? b_q[31:16] : b_q[15:0]};
        full  = prod_q + {mpart, 16'b0};
    end
    // Next-state logic: operand latch, multiply/divide sequencing, flush abort
    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        div_cnt_d = div_cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        r_d       = r_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        prod_d    = prod_q;
        res_d     = res_q;
        hilo_d    = hilo_q;
        case (state_q)
            IDLE: if (bus.start && !bus.int_flush) begin
                a_d       = abs_a;
                b_d       = abs_b;
                neg_d     = sgn & (bus.src_a[31] ^ bus.src_b[31]);
                rneg_d    = sgn & bus.src_a[31];
                r_d       = '0;
                prod_d    = '0;
                mul_cnt_d = 1'b0;
                div_cnt_d = '0;
                if (!bus.op[1]) state_d = MUL;
                else if (bus.src_b == '0) begin
                    state_d = DONE;
                    res_d   = {bus.src_a, 32'hFFFF_FFFF};
                end else state_d = DIV;
            end
            MUL: if (bus.int_flush) state_d = IDLE;
            else begin
                mul_cnt_d = 1'b1;
                if (!mul_cnt_q) prod_d = {16'b0, mpart};
                else begin
                    res_d   = neg_q ? -full : full;
                    state_d = DONE;
                end
            end
            DIV: if (bus.int_flush) state_d = IDLE;
            else begin
                a_d       = q_nx;
                r_d       = r_nx;
                div_cnt_d = div_cnt_q + 5'd1;
                if (div_cnt_q == 5'd31) begin
                    res_d   = {rneg_q ? -r_nx : r_nx, neg_q ? -q_nx : q_nx};
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                if (!bus.int_flush) hilo_d = res_q;
            end
        endcase
    end
    assign bus.hilo_valid = (state_q == DONE) && !bus.int_flush;
    assign bus.hilo_out   = bus.hilo_valid ? res_q : hilo_q;
    assign bus.busy       = state_q != IDLE;
    assign bus.exe_stall  = !bus.int_flush && ((state_q == IDLE && bus.start) || state_q == MUL || state_q == DIV);
    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mul_cnt_q <= 1'b0;
            div_cnt_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            prod_q    <= '0;
            res_q     <= '0;
            hilo_q    <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            div_cnt_q <= div_cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            r_q       <= r_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            prod_q    <= prod_d;
            res_q     <= res_d;
            hilo_q    <= hilo_d;
        end
    end
endmodule
